alu_pipe: RTL

Parametrised successor to the 16-bit single-cycle ALU, with registered outputs and a valid/ready handshake on both input and output.
- Adds an arithmetic right shift and signed/unsigned set-less-than.
- Adds an iterative shift-add multiplier that takes several cycles.
- Adds registered status flags: Zero, Negative, Carry, Overflow.
- Sits between operand select and writeback in the datapath; the handshake lets a multi-cycle op stall the core.

---
 rtl/alu_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake on both sides and an
// iterative shift-add multiplier that stalls the input while it runs.
module alu_pipe #(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] FirstInput,
   input  logic [WIDTH-1:0] SecondInput,
   input  logic [3:0]       ALUOp,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] OutputData,
   output logic             OutValid,
   input  logic             OutReady,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry,
   output logic             Overflow
);
   localparam int SW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d, mb_q, mb_d, res;
   logic [2*WIDTH-1:0] mc_q, mc_d, acc_q, acc_d, acc_step;
   logic [SW-1:0] cnt_q, cnt_d, sh;
   logic [3:0] flg_q, flg_d;
   logic [WIDTH:0] sum, diff;
   logic res_c, res_v, accept, is_mul;
   assign sh       = SecondInput[SW-1:0];
   assign sum      = {1'b0, FirstInput} + {1'b0, SecondInput};
   assign diff     = {1'b0, FirstInput} - {1'b0, SecondInput};
   assign InReady  = (state_q == IDLE) || (state_q == HOLD && OutReady);
   assign accept   = InValid && InReady;
   assign is_mul   = MUL_EN && ALUOp == 4'd11;
   assign acc_step = acc_q + (mb_q[0] ? mc_q : '0);
   always_comb begin
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      case (ALUOp)
         4'd1: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (FirstInput[WIDTH-1] == SecondInput[WIDTH-1]) && (sum[WIDTH-1] != FirstInput[WIDTH-1]);
         end
         4'd2: begin
            res   = diff[WIDTH-1:0];
            res_c = diff[WIDTH];
            res_v = (FirstInput[WIDTH-1] != SecondInput[WIDTH-1]) && (diff[WIDTH-1] != FirstInput[WIDTH-1]);
         end
         4'd3:    res = FirstInput | SecondInput;
         4'd4:    res = FirstInput & SecondInput;
         4'd5:    res = FirstInput << sh;
         4'd6:    res = FirstInput >> sh;
         4'd7:    res = FirstInput ^ SecondInput;
         4'd8:    res = WIDTH'($signed(FirstInput) >>> sh);
         4'd9:    res = WIDTH'($signed(FirstInput) < $signed(SecondInput));
         4'd10:   res = WIDTH'(FirstInput < SecondInput);
         default: res = '0;
      endcase
   end
   // flags are packed {Overflow, Carry, Negative, Zero}
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      flg_d   = flg_q;
      mc_d    = mc_q;
      mb_d    = mb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      if (state_q == BUSY) begin
         acc_d = acc_step;
         mc_d  = mc_q << 1;
         mb_d  = mb_q >> 1;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == SW'(WIDTH - 1)) begin
            state_d = HOLD;
            out_d   = acc_step[WIDTH-1:0];
            flg_d   = {1'b0, |acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0};
         end
      end else if (accept && is_mul) begin
         state_d = BUSY;
         mc_d    = {{WIDTH{1'b0}}, FirstInput};
         mb_d    = SecondInput;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (accept) begin
         state_d = HOLD;
         out_d   = res;
         flg_d   = {res_v, res_c, res[WIDTH-1], res == '0};
      end else if (state_q == HOLD && OutReady) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         out_q   <= '0;
         flg_q   <= '0;
         mc_q    <= '0;
         mb_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         flg_q   <= flg_d;
         mc_q    <= mc_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end
   assign OutputData = out_q;
   assign OutValid   = state_q == HOLD;
   assign Overflow   = flg_q[3];
   assign Carry      = flg_q[2];
   assign Negative   = flg_q[1];
   assign Zero       = flg_q[0];
endmodule
